// File: rtl/pow_pkg.sv
// rtl/pow_pkg.sv - shared state encoding and exponent-width helper for pow_n
package pow_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to hold 0..max_exp.
  function automatic int exp_width(input int max_exp);
    int w;
    w = 1;
    while ((2 ** w) < (max_exp + 1)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential shift-add multiplier, one multiplier bit per cycle, LSB first
module mul_seq #(
  parameter int AW = 40,
  parameter int BW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] mcand_i,
  input  logic [BW-1:0] mplier_i,
  output logic          done_o,
  output logic [AW-1:0] prod_o
);
  localparam int            CW   = (BW > 1) ? $clog2(BW) : 1;
  localparam logic [CW-1:0] LAST = CW'(BW - 1);

  logic          active_q, active_d;
  logic [AW-1:0] mcand_q, mcand_d;
  logic [BW-1:0] mplier_q, mplier_d;
  logic [AW-1:0] prod_q, prod_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [AW-1:0] sum;

  // The product is kept at AW bits; the caller guarantees it never exceeds that.
  assign sum    = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o = active_q && (bit_q == LAST);
  assign prod_o = sum;

  always_comb begin
    active_d = active_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    bit_d    = bit_q;
    if (start_i) begin
      active_d = 1'b1;
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      prod_d   = '0;
      bit_d    = '0;
    end else if (active_q) begin
      prod_d   = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      bit_d    = bit_q + CW'(1);
      if (bit_q == LAST) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      active_q <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      bit_q    <= '0;
    end else begin
      active_q <= active_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      bit_q    <= bit_d;
    end
  end

endmodule

// File: rtl/pow_n.sv
// rtl/pow_n.sv - sequential integer power a^e built on a repeated shift-add multiply
module pow_n
  import pow_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_EXP = 5,
  parameter int EXP_W   = exp_width(MAX_EXP)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [WIDTH-1:0]           a_bi,
  input  logic [EXP_W-1:0]           exp_bi,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [WIDTH*MAX_EXP-1:0]   y_bo
);
  localparam int               YW    = WIDTH * MAX_EXP;
  localparam logic [EXP_W-1:0] MAX_E = EXP_W'(MAX_EXP);
  localparam logic [EXP_W-1:0] ONE_E = EXP_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [YW-1:0]    acc_q, acc_d;
  logic [YW-1:0]    y_q, y_d;
  logic [EXP_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic             mul_start;
  logic [YW-1:0]    mul_mcand;
  logic [WIDTH-1:0] mul_mplier;
  logic             mul_done;
  logic [YW-1:0]    mul_prod;

  mul_seq #(
    .AW(YW),
    .BW(WIDTH)
  ) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (mul_start),
    .mcand_i  (mul_mcand),
    .mplier_i (mul_mplier),
    .done_o   (mul_done),
    .prod_o   (mul_prod)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    y_d        = y_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    mul_start  = 1'b0;
    mul_mcand  = acc_q;
    mul_mplier = a_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start_i) begin
          if (exp_bi > MAX_E) begin
            err_d = 1'b1;
          end else begin
            a_d = a_bi;
            if (exp_bi == '0) begin
              state_d = ST_DONE;
              y_d     = YW'(1);
              done_d  = 1'b1;
            end else if (exp_bi == ONE_E) begin
              state_d = ST_DONE;
              y_d     = YW'(a_bi);
              done_d  = 1'b1;
            end else begin
              // First multiply starts on the accepting edge, straight from the inputs.
              state_d    = ST_MUL;
              acc_d      = YW'(a_bi);
              cnt_d      = exp_bi - ONE_E;
              busy_d     = 1'b1;
              mul_start  = 1'b1;
              mul_mcand  = YW'(a_bi);
              mul_mplier = a_bi;
            end
          end
        end
      end
      ST_MUL: begin
        busy_d = 1'b1;
        if (mul_done) begin
          acc_d = mul_prod;
          cnt_d = cnt_q - ONE_E;
          if (cnt_q == ONE_E) begin
            state_d = ST_DONE;
            y_d     = mul_prod;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            // Chain the next multiply without an idle cycle.
            mul_start = 1'b1;
            mul_mcand = mul_prod;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign y_bo   = y_q;

endmodule

// File: doc/pow_n.md
POW_N -- requirements
Module: pow_n

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, at least 2.
REQ-002 Parameter MAX_EXP, default 5: largest accepted exponent, at least 2.
REQ-003 Parameter EXP_W, default 3: exponent port width, equal to ceil(log2(MAX_EXP+1)).
REQ-004 clk_i  in  1: single clock; all state changes on the rising edge.
REQ-005 rst_i  in  1: asynchronous, active-low reset.
REQ-006 a_bi  in  WIDTH: unsigned base.
REQ-007 exp_bi  in  EXP_W: unsigned exponent.
REQ-008 start_i  in  1: request; sampled only when the block is idle (IDLE or DONE).
REQ-009 busy_o  out  1: computation in progress.
REQ-010 done_o  out  1: one-cycle pulse; y_bo holds a new result.
REQ-011 err_o  out  1: one-cycle pulse; start was rejected because exp_bi > MAX_EXP.
REQ-012 y_bo  out  WIDTH*MAX_EXP: unsigned result a^e, held until the next accepted start completes.

Function
REQ-013 States: IDLE, MUL, DONE; the default after reset is IDLE.
REQ-014 IDLE or DONE with start_i=1 and exp_bi<=MAX_EXP: capture a_bi and exp_bi into internal registers; later changes on the inputs have no effect on the result.
REQ-015 Exponent e=0: go to DONE on the next edge with y_bo=1.
REQ-016 Exponent e=1: go to DONE on the next edge with y_bo=a, zero-extended.
REQ-017 Exponent e>=2: load acc=a and cnt=e-1, then go to MUL.
REQ-018 MUL performs one multiply, acc*a, with the mul_seq shift-add sub-module: 1 multiplier bit per cycle, LSB first, WIDTH cycles per multiply.
REQ-019 End of each multiply: acc takes the product truncated to WIDTH*MAX_EXP bits (lossless because acc <= a^(MAX_EXP-1)), and cnt decrements.
REQ-020 cnt reaches 0: go to DONE with y_bo=acc.
REQ-021 Latency: done_o rises (e-1)*WIDTH+1 cycles after the accepting edge for e>=2, and 1 cycle after it for e<=1.
REQ-022 busy_o is 1 exactly while the state is MUL; it is 0 in IDLE and DONE.
REQ-023 DONE lasts one cycle with done_o=1, then moves to IDLE; a valid start in DONE is accepted (back-to-back operation) and the next state follows REQ-015 to REQ-017.
REQ-024 start_i is ignored while in MUL; no error pulse is produced.
REQ-025 Start with exp_bi>MAX_EXP while idle: not accepted; err_o=1 for one cycle; state and y_bo unchanged; busy_o stays 0.
REQ-026 y_bo changes only on entry to DONE.

Reset
REQ-027 rst_i=0 at any time, including mid-MUL, immediately forces IDLE and busy_o=0, done_o=0, err_o=0, y_bo=0, and clears acc, cnt and the sub-module state.
REQ-028 After rst_i returns to 1, the first rising edge with a valid start is accepted normally.

Structure
REQ-029 Package pow_pkg holds the state encoding (IDLE, MUL, DONE) and the EXP_W calculation function.
REQ-030 Sub-module mul_seq: sequential shift-add multiplier, parametrised in accumulator width and multiplier width, with start/done ports; one instance.
REQ-031 No combinational path from inputs to outputs; all outputs are registered.

Verification (defaults WIDTH=8, MAX_EXP=5)
REQ-032 Directed case 1: a=8, e=3, start for 1 cycle -> busy_o high for 16 cycles, then done_o pulse 17 cycles after the accepting edge, y_bo=512.
REQ-033 Directed case 2: a=255, e=3 -> y_bo=16581375 (0xFD02FF); then a=3, e=5 started in the DONE cycle -> accepted, y_bo=243 after 33 cycles.
REQ-034 Directed case 3: e=0 with a=200 -> y_bo=1 after 1 cycle; e=1 with a=200 -> y_bo=200 after 1 cycle; busy_o stays 0 throughout.
REQ-035 Directed case 4: e=6 -> err_o pulse, no busy_o, y_bo unchanged; a start pulse and a_bi changes during MUL -> ignored, result unaffected.
REQ-036 Directed case 5: rst_i=0 at cycle 5 of a=7, e=4 -> all outputs 0 immediately; after release, a=2, e=5 -> y_bo=32 after 33 cycles.
